reward_laser_ctrl: RTL and testbench

//   Timed controller for the laser power-up. It latches a laser pick-up and drives the

---
 rtl/reward_laser_ctrl.sv | 99 +++++++++
 tb/tb_reward_laser_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reward_laser_ctrl.sv
// Laser power-up timer: latches a pickup, counts the reward down in prescaled ticks,
// blinks the beam during the final warning window and pulses laser_expire at the end.
module reward_laser_ctrl #(
    parameter int unsigned CLK_DIV  = 6_250_000,
    parameter int unsigned DURATION = 40,
    parameter int unsigned WARN     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_reward,
    input  logic       pickup,
    output logic       reward_laser,
    output logic       laser_warn,
    output logic [7:0] laser_remaining,
    output logic       laser_expire
);

    localparam int unsigned PW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {StIdle, StActive, StWarn} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      remaining_q, remaining_d;
    logic            blink_q, blink_d;
    logic            expire_d;
    logic            tick;

    assign tick = (presc_q == PW'(CLK_DIV - 1));

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        blink_d     = blink_q;
        expire_d    = 1'b0;
        // enable_reward low freezes everything, including pickups
        if (enable_reward) begin
            if (pickup) begin
                state_d     = StActive;
                remaining_d = 8'(DURATION);
                presc_d     = '0;
                blink_d     = 1'b0;
            end else if (state_q == StIdle) begin
                presc_d = '0;
            end else if (!tick) begin
                presc_d = presc_q + PW'(1);
            end else begin
                presc_d = '0;
                case (state_q)
                    StActive: begin
                        remaining_d = remaining_q - 8'd1;
                        if (remaining_d == 8'(WARN)) begin
                            state_d = StWarn;
                            blink_d = 1'b0;
                        end
                    end
                    StWarn: begin
                        if (remaining_q > 8'd1) begin
                            remaining_d = remaining_q - 8'd1;
                            blink_d     = ~blink_q;
                        end else begin
                            remaining_d = 8'd0;
                            state_d     = StIdle;
                            blink_d     = 1'b0;
                            expire_d    = 1'b1;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Outputs are registered from the next-state values so they match the state after each edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            presc_q         <= '0;
            remaining_q     <= 8'd0;
            blink_q         <= 1'b0;
            reward_laser    <= 1'b0;
            laser_warn      <= 1'b0;
            laser_remaining <= 8'd0;
            laser_expire    <= 1'b0;
        end else begin
            state_q         <= state_d;
            presc_q         <= presc_d;
            remaining_q     <= remaining_d;
            blink_q         <= blink_d;
            reward_laser    <= enable_reward &
                               ((state_d == StActive) | ((state_d == StWarn) & blink_d));
            laser_warn      <= enable_reward & (state_d == StWarn);
            laser_remaining <= remaining_d;
            laser_expire    <= expire_d;
        end
    end

endmodule

// File: tb/tb_reward_laser_ctrl.sv
// Bench for reward_laser_ctrl: directed scenarios plus random stimulus, all checked against
// an elapsed-time reference model.
module tb_reward_laser_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int DURATION = 6;
    localparam int WARN     = 2;

    logic       clk;
    logic       rst;
    logic       enable_reward;
    logic       pickup;
    logic       reward_laser;
    logic       laser_warn;
    logic [7:0] laser_remaining;
    logic       laser_expire;

    int vectors;
    int miscompares;

    // Reference model: reward is "active" plus a count of enabled edges since the pickup
    bit         m_active;
    int         m_e;
    logic       m_expire;
    logic       m_laser;
    logic       m_warn;
    logic [7:0] m_rem;

    reward_laser_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .DURATION (DURATION),
        .WARN     (WARN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable_reward   (enable_reward),
        .pickup          (pickup),
        .reward_laser    (reward_laser),
        .laser_warn      (laser_warn),
        .laser_remaining (laser_remaining),
        .laser_expire    (laser_expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic r, input logic en, input logic pk);
        int rem;
        bit en_eff;
        rst           = r;
        enable_reward = en;
        pickup        = pk;
        @(posedge clk);
        m_expire = 1'b0;
        en_eff   = en && !r;
        if (r) begin
            m_active = 1'b0;
            m_e      = 0;
        end else if (en) begin
            if (pk) begin
                m_active = 1'b1;
                m_e      = 0;
            end else if (m_active) begin
                m_e++;
                if (m_e == DURATION * CLK_DIV) begin
                    m_active = 1'b0;
                    m_e      = 0;
                    m_expire = 1'b1;
                end
            end
        end
        rem     = m_active ? DURATION - m_e / CLK_DIV : 0;
        m_rem   = 8'(rem);
        m_warn  = en_eff && m_active && (rem <= WARN);
        m_laser = en_eff && m_active && ((rem > WARN) || (((WARN - rem) % 2) == 1));
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 6; k++) begin
            step((k < 3), 1'b1, (k < 3));
            vectors++;
            if ({reward_laser, laser_warn, laser_expire, laser_remaining} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset k=%0d: got laser=%b warn=%b exp=%b rem=%0d, want all 0",
                         k, reward_laser, laser_warn, laser_expire, laser_remaining);
            end
        end
    endtask

    task automatic test_full_run();
        int n_exp = 0;
        int exp_at = -1;
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) begin
            step(1'b0, 1'b1, (k == 0));
            vectors++;
            if ({reward_laser, laser_warn, laser_expire, laser_remaining} !==
                {m_laser, m_warn, m_expire, m_rem}) begin
                miscompares++;
                $display("FAIL full_run k=%0d: got l/w/e/r=%b%b%b/%0d want %b%b%b/%0d", k,
                         reward_laser, laser_warn, laser_expire, laser_remaining,
                         m_laser, m_warn, m_expire, m_rem);
            end
            if (laser_expire === 1'b1) begin
                n_exp++;
                exp_at = k;
            end
            if (k == 0 || k == 4 || k == 8 || k == 12 || k == 16 || k == 20) begin
                vectors++;
                if (laser_remaining !== 8'(6 - k / 4) || reward_laser !== (k != 16) ||
                    laser_warn !== (k >= 16)) begin
                    miscompares++;
                    $display("FAIL full_run_pt k=%0d: got rem=%0d laser=%b warn=%b", k,
                             laser_remaining, reward_laser, laser_warn);
                end
            end
        end
        vectors++;
        if (n_exp != 1 || exp_at != 24) begin
            miscompares++;
            $display("FAIL full_run_expire: got %0d pulses last at %0d, want 1 at 24",
                     n_exp, exp_at);
        end
    endtask

    task automatic test_rearm_warn();
        int n_exp = 0;
        int exp_at = -1;
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 1'b1, (k == 0 || k == 18));
            vectors++;
            if ({reward_laser, laser_warn, laser_expire, laser_remaining} !==
                {m_laser, m_warn, m_expire, m_rem}) begin
                miscompares++;
                $display("FAIL rearm k=%0d: got l/w/e/r=%b%b%b/%0d want %b%b%b/%0d", k,
                         reward_laser, laser_warn, laser_expire, laser_remaining,
                         m_laser, m_warn, m_expire, m_rem);
            end
            if (laser_expire === 1'b1) begin
                n_exp++;
                exp_at = k;
            end
            if (k == 18) begin
                vectors++;
                if (laser_remaining !== 8'd6 || laser_warn !== 1'b0 || reward_laser !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rearm_pt: got rem=%0d warn=%b laser=%b want 6/0/1",
                             laser_remaining, laser_warn, reward_laser);
                end
            end
        end
        vectors++;
        if (n_exp != 1 || exp_at != 42) begin
            miscompares++;
            $display("FAIL rearm_expire: got %0d pulses last at %0d, want 1 at 42",
                     n_exp, exp_at);
        end
    endtask

    task automatic test_pause();
        int n_exp = 0;
        int exp_at = -1;
        int bad = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 56; k++) begin
            // a pickup offered while paused must be ignored
            step(1'b0, !(k >= 6 && k <= 29), (k == 0 || k == 15));
            vectors++;
            if ({reward_laser, laser_warn, laser_expire, laser_remaining} !==
                {m_laser, m_warn, m_expire, m_rem}) begin
                miscompares++;
                $display("FAIL pause k=%0d: got l/w/e/r=%b%b%b/%0d want %b%b%b/%0d", k,
                         reward_laser, laser_warn, laser_expire, laser_remaining,
                         m_laser, m_warn, m_expire, m_rem);
            end
            if (laser_expire === 1'b1) begin
                n_exp++;
                exp_at = k;
            end
            if (k >= 6 && k <= 29 && (reward_laser !== 1'b0 || laser_remaining !== 8'd5)) bad++;
            if (k == 30) begin
                vectors++;
                if (reward_laser !== 1'b1) begin
                    miscompares++;
                    $display("FAIL pause_resume: got laser=%b want 1", reward_laser);
                end
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL pause_hold: %0d paused cycles not dark with rem=5, want 0", bad);
        end
        vectors++;
        if (n_exp != 1 || exp_at != 48) begin
            miscompares++;
            $display("FAIL pause_expire: got %0d pulses last at %0d, want 1 at 48",
                     n_exp, exp_at);
        end
    endtask

    task automatic test_pickup_final_tick();
        int n_exp = 0;
        int exp_at = -1;
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 1'b1, (k == 0 || k == 24));
            vectors++;
            if ({reward_laser, laser_warn, laser_expire, laser_remaining} !==
                {m_laser, m_warn, m_expire, m_rem}) begin
                miscompares++;
                $display("FAIL final_tick k=%0d: got l/w/e/r=%b%b%b/%0d want %b%b%b/%0d", k,
                         reward_laser, laser_warn, laser_expire, laser_remaining,
                         m_laser, m_warn, m_expire, m_rem);
            end
            if (laser_expire === 1'b1) begin
                n_exp++;
                exp_at = k;
            end
            if (k == 24) begin
                vectors++;
                if (laser_expire !== 1'b0 || laser_remaining !== 8'd6 || reward_laser !== 1'b1 ||
                    laser_warn !== 1'b0) begin
                    miscompares++;
                    $display("FAIL final_tick_pt: got exp=%b rem=%0d laser=%b warn=%b want 0/6/1/0",
                             laser_expire, laser_remaining, reward_laser, laser_warn);
                end
            end
        end
        vectors++;
        if (n_exp != 1 || exp_at != 48) begin
            miscompares++;
            $display("FAIL final_tick_expire: got %0d pulses last at %0d, want 1 at 48",
                     n_exp, exp_at);
        end
    endtask

    task automatic test_reset_mid();
        int n_exp = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step((k == 10), 1'b1, (k == 0));
            vectors++;
            if ({reward_laser, laser_warn, laser_expire, laser_remaining} !==
                {m_laser, m_warn, m_expire, m_rem}) begin
                miscompares++;
                $display("FAIL reset_mid k=%0d: got l/w/e/r=%b%b%b/%0d want %b%b%b/%0d", k,
                         reward_laser, laser_warn, laser_expire, laser_remaining,
                         m_laser, m_warn, m_expire, m_rem);
            end
            if (laser_expire === 1'b1) n_exp++;
            if (k == 10) begin
                vectors++;
                if ({reward_laser, laser_warn, laser_expire, laser_remaining} !== 11'd0) begin
                    miscompares++;
                    $display("FAIL reset_mid_pt: got laser=%b warn=%b exp=%b rem=%0d want 0",
                             reward_laser, laser_warn, laser_expire, laser_remaining);
                end
            end
        end
        vectors++;
        if (n_exp != 0) begin
            miscompares++;
            $display("FAIL reset_mid_expire: got %0d pulses, want 0", n_exp);
        end
    endtask

    task automatic test_random();
        logic prev_exp = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 39) == 0));
            vectors++;
            if ({reward_laser, laser_warn, laser_expire, laser_remaining} !==
                {m_laser, m_warn, m_expire, m_rem}) begin
                miscompares++;
                $display("FAIL random k=%0d: got l/w/e/r=%b%b%b/%0d want %b%b%b/%0d", k,
                         reward_laser, laser_warn, laser_expire, laser_remaining,
                         m_laser, m_warn, m_expire, m_rem);
            end
            if (prev_exp === 1'b1 && laser_expire === 1'b1) begin
                miscompares++;
                $display("FAIL random_double_expire k=%0d: got 2 consecutive pulses, want 1", k);
            end
            prev_exp = laser_expire;
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        m_active      = 1'b0;
        m_e           = 0;
        rst           = 1'b1;
        enable_reward = 1'b1;
        pickup        = 1'b1;
        test_reset();
        test_full_run();
        test_rearm_warn();
        test_pause();
        test_pickup_final_tick();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
